packetmon_64: RTL and testbench

PACKETMON_64 -- requirements
Module: packetmon_64

---
 rtl/packetgen_pkg.sv | 31 +++
 rtl/packetmon_64_sat_counter.sv | 27 ++
 rtl/packetmon_64.sv | 165 ++++++++++++++++
 tb/tb_packetmon_64.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/packetgen_pkg.sv
// Shared definitions for the packet monitor: FSM encoding, Ethernet header
// byte offsets and small keep-mask helpers.
package packetgen_pkg;

  typedef enum logic [1:0] {
    HDR0 = 2'd0,
    HDR1 = 2'd1,
    BODY = 2'd2
  } state_t;

  localparam int unsigned BEAT_BYTES  = 8;
  localparam int unsigned MAC_BYTES   = 6;
  localparam int unsigned DMAC_OFF    = 0;
  localparam int unsigned ETYPE_OFF   = DMAC_OFF + 2 * MAC_BYTES;
  localparam int unsigned PAYLOAD_OFF = ETYPE_OFF + 2;
  localparam int unsigned MIN_LEN     = PAYLOAD_OFF;
  localparam int unsigned LEN_WIDTH   = 16;

  function automatic logic [3:0] popcount8(input logic [7:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + 4'(k[i]);
    return c;
  endfunction

  // True when the set bits form one run starting at bit 0 (empty included).
  function automatic logic keep_contig(input logic [7:0] k);
    return (k & (k + 8'd1)) == 8'd0;
  endfunction

endpackage

// File: rtl/packetmon_64_sat_counter.sv
// Saturating accumulator: adds inc_val when inc_en, sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_en,
  input  logic [INC_WIDTH-1:0] inc_val,
  output logic [WIDTH-1:0]     count
);

  localparam int unsigned SUM_W = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

  logic [SUM_W-1:0] sum;

  assign sum = SUM_W'(count) + SUM_W'(inc_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc_en) begin
      count <= (|sum[SUM_W-1:WIDTH]) ? '1 : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/packetmon_64.sv
// Per-flow Ethernet frame monitor on a 64-bit AXI-Stream sink: classifies
// frames by destination MAC, checks fill, length and keep format, counts.
module packetmon_64
  import packetgen_pkg::*;
#(
  parameter int unsigned             N_FLOWS   = 4,
  parameter logic [48*N_FLOWS-1:0]   D_MACS    = {48'hABCDEF000001, 48'hABCDEF000002,
                                                  48'hABCDEF000003, 48'hABCDEF000004},
  parameter logic [11*N_FLOWS-1:0]   SIZES     = {11'd192, 11'd192, 11'd192, 11'd192},
  parameter logic [8*N_FLOWS-1:0]    PAYLOADS  = {8'hAA, 8'hBB, 8'hCC, 8'hDD},
  parameter int unsigned             CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [63:0]                    s_axis_tdata,
  input  logic [7:0]                     s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic [N_FLOWS*CNT_WIDTH-1:0]   pkt_cnt,
  output logic [N_FLOWS*CNT_WIDTH-1:0]   byte_cnt,
  output logic [N_FLOWS*CNT_WIDTH-1:0]   err_cnt,
  output logic [CNT_WIDTH-1:0]           unmatched_cnt,
  output logic                           frame_done
);

  localparam int unsigned FLOW_W = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_new;
  logic [LEN_WIDTH:0]   len_sum;
  logic                 err_q, match_q;
  logic [FLOW_W-1:0]    flow_q;

  logic [3:0]           popcnt;
  logic [47:0]          hdr_mac;
  logic                 hdr_match, cur_match;
  logic [FLOW_W-1:0]    hdr_flow, cur_flow;
  logic [10:0]          exp_size;
  logic [7:0]           exp_pay;
  logic                 fmt_bad, pay_bad, err_all;
  logic                 end_frame, short_frame;
  logic                 good_inc, bad_inc, unmatched_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HDR0;
    else        state_q <= state_d;
  end

  // Beat classification, frame verdict and next state.
  always_comb begin
    state_d   = state_q;
    popcnt    = popcount8(s_axis_tkeep);
    len_sum   = {1'b0, len_q} + (LEN_WIDTH+1)'(popcnt);
    len_new   = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

    hdr_mac = '0;
    for (int b = 0; b < int'(MAC_BYTES); b++) begin
      hdr_mac[8*(int'(MAC_BYTES)-1-b) +: 8] = s_axis_tdata[8*(int'(DMAC_OFF)+b) +: 8];
    end

    hdr_match = 1'b0;
    hdr_flow  = '0;
    for (int i = int'(N_FLOWS) - 1; i >= 0; i--) begin
      if (hdr_mac == D_MACS[48*i +: 48]) begin
        hdr_match = 1'b1;
        hdr_flow  = FLOW_W'(i);
      end
    end

    cur_match = (state_q == HDR0) ? hdr_match : match_q;
    cur_flow  = (state_q == HDR0) ? hdr_flow  : flow_q;

    exp_size = '0;
    exp_pay  = '0;
    for (int i = 0; i < int'(N_FLOWS); i++) begin
      if (cur_flow == FLOW_W'(i)) begin
        exp_size = SIZES[11*i +: 11];
        exp_pay  = PAYLOADS[8*i +: 8];
      end
    end

    fmt_bad = s_axis_tlast ? !keep_contig(s_axis_tkeep) : (s_axis_tkeep != 8'hFF);

    // Fill starts at frame byte 14: lanes 6..7 of beat 1, every body lane.
    pay_bad = 1'b0;
    for (int l = 0; l < int'(BEAT_BYTES); l++) begin
      if (s_axis_tkeep[l] && (s_axis_tdata[8*l +: 8] != exp_pay) &&
          ((state_q == BODY) ||
           ((state_q == HDR1) && (l >= int'(PAYLOAD_OFF) - int'(BEAT_BYTES))))) begin
        pay_bad = 1'b1;
      end
    end

    err_all       = err_q | fmt_bad | pay_bad | (len_new != LEN_WIDTH'(exp_size));
    end_frame     = s_axis_tvalid & s_axis_tlast;
    short_frame   = len_new < LEN_WIDTH'(MIN_LEN);
    unmatched_inc = end_frame & (short_frame | ~cur_match);
    good_inc      = end_frame & ~short_frame & cur_match & ~err_all;
    bad_inc       = end_frame & ~short_frame & cur_match &  err_all;

    if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        state_d = HDR0;
      end else begin
        case (state_q)
          HDR0:    state_d = HDR1;
          HDR1:    state_d = BODY;
          default: state_d = BODY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      err_q      <= 1'b0;
      match_q    <= 1'b0;
      flow_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= end_frame;
      if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          len_q   <= '0;
          err_q   <= 1'b0;
          match_q <= 1'b0;
        end else begin
          len_q <= len_new;
          err_q <= err_q | fmt_bad | pay_bad;
          if (state_q == HDR0) begin
            flow_q  <= hdr_flow;
            match_q <= hdr_match;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < int'(N_FLOWS); g++) begin : g_flow
    logic hit;
    assign hit = (cur_flow == FLOW_W'(g));

    sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_pkt (
      .clk(clk), .rst_n(rst_n), .inc_en(good_inc & hit), .inc_val(1'b1),
      .count(pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH])
    );

    sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(LEN_WIDTH)) u_byte (
      .clk(clk), .rst_n(rst_n), .inc_en(good_inc & hit), .inc_val(len_new),
      .count(byte_cnt[g*CNT_WIDTH +: CNT_WIDTH])
    );

    sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_err (
      .clk(clk), .rst_n(rst_n), .inc_en(bad_inc & hit), .inc_val(1'b1),
      .count(err_cnt[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_unmatched (
    .clk(clk), .rst_n(rst_n), .inc_en(unmatched_inc), .inc_val(1'b1),
    .count(unmatched_cnt)
  );

endmodule

// File: tb/tb_packetmon_64.sv
// Directed bench for packetmon_64: good/bad/unmatched frames, back-to-back
// traffic with gaps, mid-frame reset and 4-bit counter saturation.
module tb_packetmon_64;

  // Flow 0 fills with 8'hAA, flow 3 with 8'hDD; MACs and sizes are defaults.
  localparam logic [31:0] PAYS = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  tdata = '0;
  logic [7:0]   tkeep = '0;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;

  logic [127:0] pkt_cnt, byte_cnt, err_cnt;
  logic [31:0]  unmatched_cnt;
  logic         frame_done;
  logic [15:0]  pkt4, byte4, err4;
  logic [3:0]   unm4;
  logic         done4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  packetmon_64 #(.PAYLOADS(PAYS)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .pkt_cnt(pkt_cnt),
    .byte_cnt(byte_cnt), .err_cnt(err_cnt), .unmatched_cnt(unmatched_cnt),
    .frame_done(frame_done)
  );

  packetmon_64 #(.PAYLOADS(PAYS), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .pkt_cnt(pkt4),
    .byte_cnt(byte4), .err_cnt(err4), .unmatched_cnt(unm4),
    .frame_done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [47:0] mac_of(input int f);
    return 48'hABCDEF000004 - 48'(f);
  endfunction

  function automatic logic [7:0] pay_of(input int f);
    logic [31:0] p;
    p = PAYS;
    return p[8*f +: 8];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    tvalid = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Streams one frame; hole = beat carrying only 4 bytes, abort = beat at
  // which reset is asserted and the frame dropped.
  task automatic send_frame(input logic [47:0] mac, input int n, input logic [7:0] fill,
                            input int bad_idx, input int hole, input bit gaps,
                            input int abort);
    logic [7:0] fb [256];
    int idx, beat, lanes, take;
    for (int k = 0; k < n; k++) begin
      if (k < 6)       fb[k] = mac[8*(5-k) +: 8];
      else if (k < 12) fb[k] = 8'h10 + 8'(k);
      else if (k == 12) fb[k] = 8'h08;
      else if (k == 13) fb[k] = 8'h00;
      else             fb[k] = fill;
      if (k == bad_idx) fb[k] = 8'h00;
    end
    idx  = 0;
    beat = 0;
    while (idx < n) begin
      if (gaps && (beat == 3 || beat == 10)) begin
        repeat ((beat == 3) ? 1 : 2) begin
          @(negedge clk);
          tvalid = 1'b0;
          tlast  = 1'b1;
          tkeep  = 8'h0F;
          tdata  = {$urandom, $urandom};
        end
      end
      lanes = (beat == hole) ? 4 : 8;
      take  = (n - idx < lanes) ? n - idx : lanes;
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = '0;
      tkeep  = '0;
      for (int l = 0; l < take; l++) begin
        tdata[8*l +: 8] = fb[idx+l];
        tkeep[l] = 1'b1;
      end
      tlast = (idx + take == n);
      if (beat == abort) begin
        #2 rst_n = 1'b0;
        return;
      end
      idx += take;
      beat++;
    end
  endtask

  // Sample the cycle right after the tlast beat.
  task automatic end_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done"}, 32'(frame_done), 32'd1);
  endtask

  task automatic good(input int f);
    send_frame(mac_of(f), 192, pay_of(f), -1, -1, 1'b0, -1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_pkt0", pkt_cnt[31:0], 32'd0);
    check("rst_byte0", byte_cnt[31:0], 32'd0);
    check("rst_unm", unmatched_cnt, 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    do_reset();

    // Single good frame to flow 0.
    good(0);
    end_check("t1");
    check("t1_pkt0", pkt_cnt[31:0], 32'd1);
    check("t1_byte0", byte_cnt[31:0], 32'd192);
    idle();
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(frame_done), 32'd0);

    // Fill error at byte 100.
    do_reset();
    send_frame(mac_of(0), 192, 8'hAA, 100, -1, 1'b0, -1);
    end_check("t2");
    check("t2_err0", err_cnt[31:0], 32'd1);
    check("t2_pkt0", pkt_cnt[31:0], 32'd0);
    check("t2_byte0", byte_cnt[31:0], 32'd0);
    idle();

    // Unknown destination MAC.
    do_reset();
    send_frame(48'h112233445566, 192, 8'hAA, -1, -1, 1'b0, -1);
    end_check("t3");
    check("t3_unm", unmatched_cnt, 32'd1);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("t3_pkt%0d", f), pkt_cnt[32*f +: 32], 32'd0);
      check($sformatf("t3_err%0d", f), err_cnt[32*f +: 32], 32'd0);
    end
    idle();

    // Four back-to-back frames, idle beats inside the second.
    do_reset();
    for (int f = 0; f < 4; f++) begin
      send_frame(mac_of(f), 192, pay_of(f), -1, -1, f == 1, -1);
      end_check($sformatf("t4_f%0d", f));
    end
    idle();
    for (int f = 0; f < 4; f++) begin
      check($sformatf("t4_pkt%0d", f), pkt_cnt[32*f +: 32], 32'd1);
      check($sformatf("t4_byte%0d", f), byte_cnt[32*f +: 32], 32'd192);
      check($sformatf("t4_err%0d", f), err_cnt[32*f +: 32], 32'd0);
    end
    check("t4_unm", unmatched_cnt, 32'd0);

    // Runt frame, short flow-1 frame, and a keep hole on flow 2.
    do_reset();
    send_frame(mac_of(0), 10, 8'hAA, -1, -1, 1'b0, -1);
    end_check("t5a");
    check("t5a_unm", unmatched_cnt, 32'd1);
    check("t5a_err0", err_cnt[31:0], 32'd0);
    check("t5a_pkt0", pkt_cnt[31:0], 32'd0);
    send_frame(mac_of(1), 184, pay_of(1), -1, -1, 1'b0, -1);
    end_check("t5b");
    check("t5b_err1", err_cnt[63:32], 32'd1);
    check("t5b_pkt1", pkt_cnt[63:32], 32'd0);
    check("t5b_unm", unmatched_cnt, 32'd1);
    send_frame(mac_of(2), 192, pay_of(2), -1, 10, 1'b0, -1);
    end_check("t5c");
    check("t5c_err2", err_cnt[95:64], 32'd1);
    check("t5c_pkt2", pkt_cnt[95:64], 32'd0);
    idle();

    // Reset at beat 12 of a flow-0 frame, then one good flow-1 frame.
    do_reset();
    send_frame(mac_of(0), 192, 8'hAA, -1, -1, 1'b0, 12);
    @(negedge clk);
    tvalid = 1'b0;
    #1;
    check("t6_rst_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    good(1);
    end_check("t6");
    idle();
    check("t6_pkt0", pkt_cnt[31:0], 32'd0);
    check("t6_err0", err_cnt[31:0], 32'd0);
    check("t6_pkt1", pkt_cnt[63:32], 32'd1);
    check("t6_byte1", byte_cnt[63:32], 32'd192);
    check("t6_unm", unmatched_cnt, 32'd0);

    // 17 flow-0 frames: 4-bit counters pin at 4'hF.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      good(0);
      end_check($sformatf("t7_f%0d", k));
      if (k == 14) check("t7_pkt4_at14", 32'(pkt4[3:0]), 32'hE);
    end
    idle();
    check("t7_pkt4_sat", 32'(pkt4[3:0]), 32'hF);
    check("t7_byte4_sat", 32'(byte4[3:0]), 32'hF);
    check("t7_pkt0", pkt_cnt[31:0], 32'd17);
    check("t7_byte0", byte_cnt[31:0], 32'd3264);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
